dsp_cic_iq_dec_rt: RTL and testbench
====================================

Name: dsp_cic_iq_dec_rt

Overview:
- Dual-channel (I/Q) CIC decimator with a runtime-programmable decimation ratio, output gain shift, round/saturate cut and a valid/ready output port with a 2-entry buffer.
- Successor to the fixed-ratio per-channel CIC decimators in the software-defined DFE chain. Sits between the NCO mixer outputs and the FIR compensation decimator.
- One instance replaces the separate sin and cos CIC instances. Ratio and gain change without resynthesis.

Parameters:
- BIN, 16, input sample width (signed, two's complement).
- N, 5, number of integrator/comb stages (1..8).
- M, 1, differential delay (1 or 2).
- RMAX, 64, maximum decimation ratio.
- RW, 7, width of cfg_r; must satisfy 2^RW > RMAX.
- SW, 6, width of cfg_shift.
- COUT, 16, output sample width (signed).
- CUT_METHOD, "ROUND", "ROUND" (round half up) or "TRUNC".
- BACC, derived, accumulator width = BIN + N*ceil(log2(RMAX*M)); must not be overridden.

Ports:
- clk  in  1  sample clock
- rst  in  1  synchronous, active-high reset
- din_i  in  BIN  I input sample
- din_q  in  BIN  Q input sample
- din_vld  in  1  input sample strobe; no backpressure
- cfg_load  in  1  one-cycle pulse; latches cfg_r and cfg_shift, then restarts the filter
- cfg_r  in  RW  decimation ratio
- cfg_shift  in  SW  right shift applied before the cut
- dout_i  out  COUT  I output
- dout_q  out  COUT  Q output
- dout_vld  out  1  output valid
- dout_rdy  in  1  downstream ready
- ovf  out  1  sticky: a decimated sample was dropped because the buffer was full
- sat  out  1  sticky: an output was saturated

Behaviour:
- Reset: all integrators, comb delays, counters and the buffer are cleared. dout_i=0, dout_q=0, dout_vld=0, ovf=0, sat=0. Active R=RMAX, active shift=0.
- cfg_load:
  - Next cycle: the active R becomes clamp(cfg_r, 2, RMAX) and the active shift becomes min(cfg_shift, BACC-1).
  - Integrators, combs, the decimation counter, the buffer, ovf and sat are all cleared.
  - dout_vld drops the cycle after cfg_load. Buffered samples are discarded.
  - A din_vld in the same cycle as cfg_load is ignored.
- Integrators:
  - On din_vld, each stage k does acc_k <= acc_k + acc_(k-1) (stage 0 adds the sign-extended input).
  - Arithmetic is modulo 2^BACC; wrap-around is intended.
  - Stages are chained registers, so the input-to-last-integrator latency is N valid samples.
- Decimation counter:
  - Counts din_vld from 0 to R-1.
  - When din_vld arrives with count == R-1, the last integrator value is captured into the comb input and a decimation strobe is issued; the counter returns to 0.
- Combs:
  - N registered stages, each y = x - x delayed by M decimated samples, evaluated one stage per clock after the strobe.
  - Strobe-to-comb-result latency is N clocks.
  - R >= 2 guarantees the next strobe cannot overtake the pipeline.
- Cut:
  - v = comb >>> shift (arithmetic).
  - With ROUND and shift > 0, 2^(shift-1) is added before the shift.
  - v is saturated to the COUT signed range; sat is set on clipping.
  - The cut is registered: 1 clock.
- Buffer:
  - 2-entry FIFO holding I/Q pairs. The head drives dout_i/dout_q; dout_vld = not empty.
  - A pop happens when dout_vld && dout_rdy.
  - Push and pop in the same cycle on a full buffer is accepted.
  - A push into a full buffer with no pop drops the new sample and sets ovf.
  - While dout_vld=0, dout_i/dout_q hold their last value.
- Total latency: the strobing din_vld to dout_vld is N+2 clocks (N comb stages, cut, buffer write) with an empty buffer.
- Gain: DC gain is (R*M)^N. Software selects shift = log2 of the gain for unity gain with power-of-two R.
- ovf and sat clear only on rst or cfg_load.

Test Plan:
- Unity gain: rst, then cfg_load with R=4, shift=10, N=5, M=1. Constant din_i=100, din_q=-100, din_vld every clock, dout_rdy=1. After N transient outputs, dout_i=100 and dout_q=-100 steadily; one dout_vld per 4 input valids; sat=0, ovf=0.
- Latency: same setup. Measure from the 4th din_vld after the transient to dout_vld; it must be exactly 7 clocks (N+2).
- Backpressure: dout_rdy=0 for 3 decimated periods. The buffer holds the first 2 samples and ovf=1 on the 3rd. On dout_rdy=1 the 2 held values drain in order.
- Saturation: R=64, shift=0, din_i=32767. dout_i saturates to 32767 and sat=1. Then a cfg_load with R=64, shift=30 clears sat; sat stays 0 and dout_i settles at 32767 with ROUND.
- Clamp and reconfig: cfg_load with cfg_r=1 gives R=2; cfg_load with cfg_r=100 gives R=64. A cfg_load issued mid-stream with a non-empty buffer gives dout_vld=0 on the next clock, after which the filter restarts from zero.
- Reset mid-operation: assert rst during the comb pipeline. The next clock shows all outputs and flags at 0, and no stale sample appears after rst is released.

Source files
------------

// File: rtl/dsp_cic_iq_dec_rt.sv
`default_nettype none
// ============================================================================
// Module   : dsp_cic_iq_dec_rt
// Brief    : Dual-channel (I/Q) CIC decimator with runtime decimation ratio,
//            output gain shift, round/saturate cut and a 2-entry valid/ready
//            output buffer.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_cic_iq_dec_rt #(
    parameter int    BIN        = 16,
    parameter int    N          = 5,
    parameter int    M          = 1,
    parameter int    RMAX       = 64,
    parameter int    RW         = 7,
    parameter int    SW         = 6,
    parameter int    COUT       = 16,
    parameter string CUT_METHOD = "ROUND"
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [BIN-1:0]  din_i,
    input  logic signed [BIN-1:0]  din_q,
    input  logic                   din_vld,
    input  logic                   cfg_load,
    input  logic        [RW-1:0]   cfg_r,
    input  logic        [SW-1:0]   cfg_shift,
    output logic signed [COUT-1:0] dout_i,
    output logic signed [COUT-1:0] dout_q,
    output logic                   dout_vld,
    input  logic                   dout_rdy,
    output logic                   ovf,
    output logic                   sat
);

    // Accumulator width grows by log2(R*M) bits per stage; fixed by the other parameters.
    localparam int BACC = BIN + N * $clog2(RMAX * M);
    localparam int c_VW = BACC + 1;
    localparam bit c_ROUND = (CUT_METHOD == "ROUND");
    localparam logic [RW-1:0] c_RMAX = RW'(RMAX);
    localparam logic [RW-1:0] c_RMIN = RW'(2);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic        [RW-1:0]   r_ratio;
    logic        [SW-1:0]   r_shift;
    logic        [RW-1:0]   w_ratio_clamp;
    logic        [SW-1:0]   w_shift_clamp;
    logic        [RW-1:0]   r_cnt;
    logic                   w_stb;

    logic signed [BACC-1:0] r_int_i [N];
    logic signed [BACC-1:0] r_int_q [N];

    logic signed [BACC-1:0] w_cx_i  [N];
    logic signed [BACC-1:0] w_cx_q  [N];
    logic        [N-1:0]    w_cxv;
    logic signed [BACC-1:0] r_cmb_i [N];
    logic signed [BACC-1:0] r_cmb_q [N];
    logic signed [BACC-1:0] r_dly_i [N][M];
    logic signed [BACC-1:0] r_dly_q [N][M];
    logic        [N-1:0]    r_cv;

    logic        [COUT:0]   w_cut_i;
    logic        [COUT:0]   w_cut_q;
    logic                   r_cut_vld;
    logic signed [COUT-1:0] r_cut_i;
    logic signed [COUT-1:0] r_cut_q;
    logic                   r_sat;

    logic signed [COUT-1:0] r_buf_i [2];
    logic signed [COUT-1:0] r_buf_q [2];
    logic                   r_wp;
    logic                   r_rp;
    logic        [1:0]      r_bcnt;
    logic signed [COUT-1:0] r_last_i;
    logic signed [COUT-1:0] r_last_q;
    logic                   r_ovf;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_push;
    logic                   w_drop;

    // ------------------------------------------------------------------------
    // Configuration
    // ------------------------------------------------------------------------
    // Clamp requested ratio to [2, RMAX] and shift to the accumulator width.
    always_comb begin
        w_ratio_clamp = cfg_r;
        if (cfg_r < c_RMIN)
            w_ratio_clamp = c_RMIN;
        else if (cfg_r > c_RMAX)
            w_ratio_clamp = c_RMAX;
        w_shift_clamp = cfg_shift;
        if (32'(cfg_shift) > 32'(BACC - 1))
            w_shift_clamp = SW'(BACC - 1);
    end

    // Active ratio/shift registers, updated only by reset or cfg_load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ratio <= c_RMAX;
            r_shift <= '0;
        end else if (cfg_load) begin
            r_ratio <= w_ratio_clamp;
            r_shift <= w_shift_clamp;
        end
    end

    // ------------------------------------------------------------------------
    // Decimation counter and integrators
    // ------------------------------------------------------------------------
    assign w_stb = din_vld && !cfg_load && (r_cnt == r_ratio - RW'(1));

    // Count accepted input samples modulo the active ratio.
    always_ff @(posedge clk) begin
        if (rst || cfg_load)
            r_cnt <= '0;
        else if (din_vld)
            r_cnt <= (r_cnt == r_ratio - RW'(1)) ? '0 : r_cnt + RW'(1);
    end

    // Chained integrators; wrap-around modulo 2^BACC is intentional.
    always_ff @(posedge clk) begin
        if (rst || cfg_load) begin
            for (int k = 0; k < N; k++) begin
                r_int_i[k] <= '0;
                r_int_q[k] <= '0;
            end
        end else if (din_vld) begin
            r_int_i[0] <= r_int_i[0] + BACC'(din_i);
            r_int_q[0] <= r_int_q[0] + BACC'(din_q);
            for (int k = 1; k < N; k++) begin
                r_int_i[k] <= r_int_i[k] + r_int_i[k-1];
                r_int_q[k] <= r_int_q[k] + r_int_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Comb pipeline
    // ------------------------------------------------------------------------
    // Stage inputs: stage 0 samples the last integrator on the strobe,
    // later stages take the previous stage result one clock later.
    always_comb begin
        w_cx_i[0] = r_int_i[N-1];
        w_cx_q[0] = r_int_q[N-1];
        w_cxv[0]  = w_stb;
        for (int k = 1; k < N; k++) begin
            w_cx_i[k] = r_cmb_i[k-1];
            w_cx_q[k] = r_cmb_q[k-1];
            w_cxv[k]  = r_cv[k-1];
        end
    end

    // Each comb stage subtracts its input delayed by M decimated samples.
    always_ff @(posedge clk) begin
        if (rst || cfg_load) begin
            r_cv <= '0;
            for (int k = 0; k < N; k++) begin
                r_cmb_i[k] <= '0;
                r_cmb_q[k] <= '0;
                for (int j = 0; j < M; j++) begin
                    r_dly_i[k][j] <= '0;
                    r_dly_q[k][j] <= '0;
                end
            end
        end else begin
            r_cv <= w_cxv;
            for (int k = 0; k < N; k++) begin
                if (w_cxv[k]) begin
                    r_cmb_i[k]    <= w_cx_i[k] - r_dly_i[k][M-1];
                    r_cmb_q[k]    <= w_cx_q[k] - r_dly_q[k][M-1];
                    r_dly_i[k][0] <= w_cx_i[k];
                    r_dly_q[k][0] <= w_cx_q[k];
                    for (int j = 1; j < M; j++) begin
                        r_dly_i[k][j] <= r_dly_i[k][j-1];
                        r_dly_q[k][j] <= r_dly_q[k][j-1];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Cut: optional half-LSB rounding, arithmetic shift, saturation
    // ------------------------------------------------------------------------
    // Returns {clip, value}; one guard bit keeps the rounding add from overflowing.
    function automatic logic [COUT:0] f_cut(input logic signed [BACC-1:0] x,
                                            input logic        [SW-1:0]   sh);
        logic signed [c_VW-1:0] v;
        logic        [COUT-1:0] o;
        logic                   clip;
        v = {x[BACC-1], x};
        if (c_ROUND && (sh != '0))
            v = v + (c_VW'(1) << (sh - SW'(1)));
        v = v >>> sh;
        clip = !((v[c_VW-1:COUT-1] == '0) || (v[c_VW-1:COUT-1] == '1));
        if (clip)
            o = v[c_VW-1] ? {1'b1, {(COUT-1){1'b0}}} : {1'b0, {(COUT-1){1'b1}}};
        else
            o = v[COUT-1:0];
        return {clip, o};
    endfunction

    // Cut both channels from the last comb stage.
    always_comb begin
        w_cut_i = f_cut(r_cmb_i[N-1], r_shift);
        w_cut_q = f_cut(r_cmb_q[N-1], r_shift);
    end

    // Register the cut result and record any clipping in the sticky flag.
    always_ff @(posedge clk) begin
        if (rst || cfg_load) begin
            r_cut_vld <= 1'b0;
            r_cut_i   <= '0;
            r_cut_q   <= '0;
            r_sat     <= 1'b0;
        end else begin
            r_cut_vld <= r_cv[N-1];
            if (r_cv[N-1]) begin
                r_cut_i <= w_cut_i[COUT-1:0];
                r_cut_q <= w_cut_q[COUT-1:0];
                if (w_cut_i[COUT] || w_cut_q[COUT])
                    r_sat <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // 2-entry output buffer
    // ------------------------------------------------------------------------
    assign w_pop  = (r_bcnt != 2'd0) && dout_rdy;
    assign w_full = (r_bcnt == 2'd2);
    assign w_push = r_cut_vld && (!w_full || w_pop);
    assign w_drop = r_cut_vld && w_full && !w_pop;

    // FIFO pointers/storage; the last popped pair is kept to hold the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_bcnt   <= 2'd0;
            r_ovf    <= 1'b0;
            r_last_i <= '0;
            r_last_q <= '0;
            for (int e = 0; e < 2; e++) begin
                r_buf_i[e] <= '0;
                r_buf_q[e] <= '0;
            end
        end else if (cfg_load) begin
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_bcnt   <= 2'd0;
            r_ovf    <= 1'b0;
            r_last_i <= dout_i;
            r_last_q <= dout_q;
        end else begin
            if (w_push) begin
                r_buf_i[r_wp] <= r_cut_i;
                r_buf_q[r_wp] <= r_cut_q;
                r_wp          <= ~r_wp;
            end
            if (w_pop) begin
                r_rp     <= ~r_rp;
                r_last_i <= r_buf_i[r_rp];
                r_last_q <= r_buf_q[r_rp];
            end
            r_bcnt <= r_bcnt + 2'(w_push) - 2'(w_pop);
            if (w_drop)
                r_ovf <= 1'b1;
        end
    end

    assign dout_vld = (r_bcnt != 2'd0);
    assign dout_i   = dout_vld ? r_buf_i[r_rp] : r_last_i;
    assign dout_q   = dout_vld ? r_buf_q[r_rp] : r_last_q;
    assign ovf      = r_ovf;
    assign sat      = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_dsp_cic_iq_dec_rt.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_cic_iq_dec_rt
// Brief    : Self-checking bench for dsp_cic_iq_dec_rt (N=5, M=1, RMAX=64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_cic_iq_dec_rt;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] din_i;
    logic signed [15:0] din_q;
    logic               din_vld;
    logic               cfg_load;
    logic        [6:0]  cfg_r;
    logic        [5:0]  cfg_shift;
    logic signed [15:0] dout_i;
    logic signed [15:0] dout_q;
    logic               dout_vld;
    logic               dout_rdy;
    logic               ovf;
    logic               sat;

    dsp_cic_iq_dec_rt #(
        .BIN(16), .N(5), .M(1), .RMAX(64), .RW(7), .SW(6), .COUT(16),
        .CUT_METHOD("ROUND")
    ) u_dut (
        .clk(clk), .rst(rst),
        .din_i(din_i), .din_q(din_q), .din_vld(din_vld),
        .cfg_load(cfg_load), .cfg_r(cfg_r), .cfg_shift(cfg_shift),
        .dout_i(dout_i), .dout_q(dout_q), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
        .ovf(ovf), .sat(sat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int q_i[$];
    int q_q[$];
    int q_t[$];

    // Record every accepted output pair with the cycle it was presented in.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (dout_vld && dout_rdy) begin
            q_i.push_back(dout_i);
            q_q.push_back(dout_q);
            q_t.push_back(cyc);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int qi_at(input int idx);
        return (idx < q_i.size()) ? q_i[idx] : -999999;
    endfunction

    function automatic int qq_at(input int idx);
        return (idx < q_q.size()) ? q_q[idx] : -999999;
    endfunction

    function automatic int gap_at(input int idx);
        return (idx > 0 && idx < q_t.size()) ? (q_t[idx] - q_t[idx-1]) : -1;
    endfunction

    task automatic step(input logic v, input int di, input int dq);
        @(posedge clk); #1;
        cfg_load = 1'b0;
        din_vld  = v;
        din_i    = 16'(di);
        din_q    = 16'(dq);
    endtask

    // Pulse cfg_load for one cycle; returns just after the edge that sampled it.
    task automatic load(input int r, input int sh, input logic v);
        @(posedge clk); #1;
        cfg_load  = 1'b1;
        cfg_r     = 7'(r);
        cfg_shift = 6'(sh);
        din_vld   = v;
        din_i     = 16'sd100;
        din_q     = -16'sd100;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        din_vld  = 1'b0;
        q_i.delete();
        q_q.delete();
        q_t.delete();
    endtask

    typedef struct {
        int r;     int sh;   int di;   int dq;   int nval;
        int idx;   int cnt;  int ei;   int eq;   int gap;  int esat;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl [NV];
    int   t_strobe;

    initial begin
        // Expected values: step response of (1+z^-1+z^-2+z^-3)^5 scaled by
        // 100/1024 with half-up rounding -> 0, 2, 35, 88, 100, 100 ...
        tbl[0]  = '{4,   10, 100,   -100,   24,  0, 6,  0,     0,      0,  0};
        tbl[1]  = '{4,   10, 100,   -100,   24,  1, 6,  2,     -2,     4,  0};
        tbl[2]  = '{4,   10, 100,   -100,   24,  2, 6,  35,    -35,    4,  0};
        tbl[3]  = '{4,   10, 100,   -100,   24,  3, 6,  88,    -88,    4,  0};
        tbl[4]  = '{4,   10, 100,   -100,   24,  4, 6,  100,   -100,   4,  0};
        tbl[5]  = '{4,   10, 100,   -100,   24,  5, 6,  100,   -100,   4,  0};
        tbl[6]  = '{1,   5,  100,   -100,   24,  5, 12, 100,   -100,   2,  0};
        tbl[7]  = '{100, 30, 100,   -100,   384, 5, 6,  100,   -100,   64, 0};
        tbl[8]  = '{64,  0,  32767, -32768, 64,  0, 1,  32767, -32768, 0,  1};
        tbl[9]  = '{64,  30, 32767, -32768, 384, 5, 6,  32767, -32768, 64, 0};
        tbl[10] = '{4,   63, 100,   -100,   24,  5, 6,  0,     0,      4,  0};

        rst = 1'b1; din_vld = 1'b0; din_i = '0; din_q = '0;
        cfg_load = 1'b0; cfg_r = '0; cfg_shift = '0; dout_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_dout_vld", dout_vld, 0);
        check("rst_dout_i",   dout_i,   0);
        check("rst_dout_q",   dout_q,   0);
        check("rst_ovf",      ovf,      0);
        check("rst_sat",      sat,      0);

        // Table-driven streaming runs, each restarted by cfg_load
        for (int v = 0; v < NV; v++) begin
            dout_rdy = 1'b1;
            load(tbl[v].r, tbl[v].sh, 1'b0);
            @(negedge clk);
            check($sformatf("v%0d_load_sat", v), sat, 0);
            check($sformatf("v%0d_load_vld", v), dout_vld, 0);
            for (int n = 0; n < tbl[v].nval; n++)
                step(1'b1, tbl[v].di, tbl[v].dq);
            repeat (12) step(1'b0, 0, 0);
            @(negedge clk);
            check($sformatf("v%0d_count", v), q_i.size(), tbl[v].cnt);
            check($sformatf("v%0d_dout_i", v), qi_at(tbl[v].idx), tbl[v].ei);
            check($sformatf("v%0d_dout_q", v), qq_at(tbl[v].idx), tbl[v].eq);
            if (tbl[v].gap > 0)
                check($sformatf("v%0d_gap", v), gap_at(tbl[v].idx), tbl[v].gap);
            check($sformatf("v%0d_sat", v), sat, tbl[v].esat);
            check($sformatf("v%0d_ovf", v), ovf, 0);
        end

        // Latency: strobing valid #23 (4th after the 5-output transient) to dout_vld
        dout_rdy = 1'b1;
        load(4, 10, 1'b0);
        t_strobe = 0;
        for (int n = 0; n < 40; n++) begin
            step(1'b1, 100, -100);
            if (n == 23) t_strobe = cyc + 1;
        end
        repeat (12) step(1'b0, 0, 0);
        check("latency", (q_t.size() > 5) ? (q_t[5] - t_strobe) : -1, 7);
        check("steady_count", q_i.size(), 10);
        check("steady_last_i", qi_at(9), 100);

        // Backpressure: 3 decimated outputs with dout_rdy=0
        dout_rdy = 1'b0;
        load(4, 10, 1'b0);
        for (int n = 0; n < 12; n++) step(1'b1, 100, -100);
        repeat (12) step(1'b0, 0, 0);
        @(negedge clk);
        check("bp_ovf",      ovf,        1);
        check("bp_vld",      dout_vld,   1);
        check("bp_nopop",    q_i.size(), 0);
        step(1'b0, 0, 0);
        dout_rdy = 1'b1;
        repeat (4) step(1'b0, 0, 0);
        @(negedge clk);
        check("bp_drained",  q_i.size(), 2);
        check("bp_first_i",  qi_at(0),   0);
        check("bp_second_i", qi_at(1),   2);
        check("bp_second_q", qq_at(1),   -2);
        check("bp_idle_vld", dout_vld,   0);
        check("bp_hold_i",   dout_i,     2);
        check("bp_hold_q",   dout_q,     -2);
        check("bp_ovf_sticky", ovf,      1);

        // Mid-stream cfg_load with a full buffer; concurrent din_vld must be ignored
        dout_rdy = 1'b0;
        load(4, 10, 1'b0);
        for (int n = 0; n < 12; n++) step(1'b1, 100, -100);
        repeat (12) step(1'b0, 0, 0);
        @(negedge clk);
        check("rc_pre_vld", dout_vld, 1);
        check("rc_pre_ovf", ovf,      1);
        load(4, 10, 1'b1);
        @(negedge clk);
        check("rc_vld_drop", dout_vld, 0);
        check("rc_ovf_clr",  ovf,      0);
        dout_rdy = 1'b1;
        for (int n = 0; n < 20; n++) step(1'b1, 100, -100);
        repeat (12) step(1'b0, 0, 0);
        @(negedge clk);
        check("rc_count", q_i.size(), 5);
        check("rc_out1_i", qi_at(1), 2);
        check("rc_out2_i", qi_at(2), 35);
        check("rc_out2_q", qq_at(2), -35);
        check("rc_out3_i", qi_at(3), 88);
        check("rc_out4_i", qi_at(4), 100);

        // Reset while a sample is in the comb pipeline
        dout_rdy = 1'b1;
        load(4, 10, 1'b0);
        for (int n = 0; n < 24; n++) step(1'b1, 100, -100);
        repeat (2) step(1'b0, 0, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mr_vld", dout_vld, 0);
        check("mr_i",   dout_i,   0);
        check("mr_q",   dout_q,   0);
        check("mr_ovf", ovf,      0);
        check("mr_sat", sat,      0);
        q_i.delete(); q_q.delete(); q_t.delete();
        repeat (15) step(1'b0, 0, 0);
        @(negedge clk);
        check("mr_no_stale", q_i.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
